// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding select codes, hazard FSM states and
// the scoreboard entry layout used by the hazard controller.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXDM = 2'b10;
  localparam logic [1:0] FWD_DMWB = 2'b01;

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  function automatic logic sb_hit(
    sb_entry_t  e,
    logic [4:0] r
  );
    return e.valid && (r != 5'd0) && (e.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(
    sb_entry_t  dm,
    sb_entry_t  wb,
    logic       use_r,
    logic [4:0] r
  );
    if (!use_r)        return FWD_RF;
    if (sb_hit(dm, r)) return FWD_EXDM;
    if (sb_hit(wb, r)) return FWD_DMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/DM/WB destination tracker with hazard and forward matches.
// FORWARDING_EN selects load-use-only stalls plus forwarding selects.
module hazard_scoreboard
  import pipeline_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       bubble_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic       id_reg_write_i,
  input  logic [4:0] id_dst_i,
  input  logic       id_mem_read_i,
  output logic       stall_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  sb_entry_t ex_d, ex_q, dm_q, wb_q;
  logic      rs_rd, rt_rd;
  logic      sb_unused;

  // Sources stay recorded for non-writing instructions so forwarding
  // still sees them; only the destination is marked invalid.
  always_comb begin
    ex_d = SB_EMPTY;
    if (!bubble_i && id_valid_i) begin
      ex_d.valid   = id_reg_write_i && (id_dst_i != 5'd0);
      ex_d.rd      = id_dst_i;
      ex_d.is_load = id_mem_read_i;
      ex_d.rs      = id_rs_i;
      ex_d.rt      = id_rt_i;
      ex_d.uses_rs = id_uses_rs_i;
      ex_d.uses_rt = id_uses_rt_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_q <= SB_EMPTY;
      dm_q <= SB_EMPTY;
      wb_q <= SB_EMPTY;
    end else begin
      ex_q <= ex_d;
      dm_q <= ex_q;
      wb_q <= dm_q;
    end
  end

  assign rs_rd = id_valid_i && id_uses_rs_i;
  assign rt_rd = id_valid_i && id_uses_rt_i;

`ifdef FORWARDING_EN
  assign stall_o = ex_q.is_load &&
                   ((rs_rd && sb_hit(ex_q, id_rs_i)) ||
                    (rt_rd && sb_hit(ex_q, id_rt_i)));
  assign fwd_a_o = fwd_sel(dm_q, wb_q, ex_q.uses_rs, ex_q.rs);
  assign fwd_b_o = fwd_sel(dm_q, wb_q, ex_q.uses_rt, ex_q.rt);
`else
  assign stall_o = (rs_rd && (sb_hit(ex_q, id_rs_i) ||
                              sb_hit(dm_q, id_rs_i) ||
                              sb_hit(wb_q, id_rs_i))) ||
                   (rt_rd && (sb_hit(ex_q, id_rt_i) ||
                              sb_hit(dm_q, id_rt_i) ||
                              sb_hit(wb_q, id_rt_i)));
  assign fwd_a_o = FWD_RF;
  assign fwd_b_o = FWD_RF;
`endif

  assign sb_unused = ^wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: sequences stalls, branch flushes and EX forwarding.
// Define FORWARDING_EN to forward results instead of stalling on RAW.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic [4:0]       id_dst,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FC_LAST = 2'(FLUSH_CYCLES - 1);

  state_e           state_d, state_q;
  logic [1:0]       cnt_d, cnt_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             hazard, flushing, stalling;
  logic [1:0]       sb_fwd_a, sb_fwd_b;

  hazard_scoreboard u_sb (
    .clk_i          (clk),
    .reset_i        (reset),
    .bubble_i       (id_ex_bubble),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rs_i   (id_uses_rs),
    .id_uses_rt_i   (id_uses_rt),
    .id_reg_write_i (id_reg_write),
    .id_dst_i       (id_dst),
    .id_mem_read_i  (id_mem_read),
    .stall_o        (hazard),
    .fwd_a_o        (sb_fwd_a),
    .fwd_b_o        (sb_fwd_b)
  );

  // The first flush cycle happens in RUN; FLUSH covers the rest.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ex_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FC_LAST;
      end
    end else if (state_q == FLUSH) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = RUN;
    end
  end

  assign flushing = ex_branch_taken || (state_q == FLUSH);
  assign stalling = hazard && !flushing;

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    fwd_a          = sb_fwd_a;
    fwd_b          = sb_fwd_b;
    if (reset) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      fwd_a          = FWD_RF;
      fwd_b          = FWD_RF;
    end else if (flushing) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hazard) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stalling && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flushing && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
